// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with grant hold limit.
// Registers a one-hot grant, its encoded index and a valid flag. A grant
// lasts until the owner drops its request or HOLD_MAX cycles elapse, and
// every grant is followed by one dead (GAP) cycle before re-arbitration.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [2:0]         owner_q, owner_d;
    logic [7:0]         gnt_q, gnt_d;
    logic [2:0]         gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;

    logic [2:0]         cand;
    logic [2:0]         winner;
    logic               win_found;
    logic               hold_hit;

    assign hold_hit = (hold_cnt_q == CNT_W'(HOLD_MAX));

    // Winner search: first requesting index starting at ptr and wrapping mod 8.
    always_comb begin
        cand      = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d     = GRANT;
                    owner_d     = winner;
                    gnt_d       = 8'b1 << winner;
                    gnt_idx_d   = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end

            GRANT: begin
                if (!req[owner_q] || hold_hit) begin
                    // Release and revoke share the same path; only a revoke
                    // (owner still requesting) raises timeout.
                    state_d     = GAP;
                    ptr_d       = owner_q + 3'd1;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = req[owner_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_valid_matches: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid_q == (|gnt_q));
    a_timeout_in_gap: assert property (@(posedge clk) disable iff (!rst_n)
        timeout_q |-> !gnt_valid_q);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8 with a grant scoreboard.
// Stimulus pushes each expected grant (index, length, revoked flag); a
// negedge monitor measures every grant the DUT presents and pops to compare.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    typedef struct {
        int idx;
        int len;
        int to;
    } exp_t;

    exp_t expq[$];
    exp_t cur_exp;
    int   checks   = 0;
    int   errors   = 0;
    bit   in_grant = 1'b0;
    int   cur_idx  = 0;
    int   cur_len  = 0;
    logic [7:0] oh;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input int idx, input int len, input int to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        expq.push_back(e);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_gnt"}, int'(gnt), 0);
        chk({name, "_idx"}, int'(gnt_idx), 0);
        chk({name, "_valid"}, int'(gnt_valid), 0);
        chk({name, "_timeout"}, int'(timeout), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #7 rst_n = 1'b1;
    endtask

    // Monitor: measure each grant and compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_grant = 1'b0;
            chk("rst_gnt", int'(gnt), 0);
        end else if (gnt_valid) begin
            oh = 8'b1 << gnt_idx;
            chk("gnt_onehot", int'(gnt), int'(oh));
            chk("timeout_in_grant", int'(timeout), 0);
            if (!in_grant) begin
                in_grant = 1'b1;
                cur_idx  = int'(gnt_idx);
                cur_len  = 1;
            end else begin
                chk("idx_stable", int'(gnt_idx), cur_idx);
                cur_len++;
            end
        end else begin
            chk("idle_gnt", int'(gnt), 0);
            chk("idle_idx", int'(gnt_idx), 0);
            if (in_grant) begin
                in_grant = 1'b0;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: actual idx %0d len %0d required none", cur_idx, cur_len);
                end else begin
                    cur_exp = expq.pop_front();
                    chk("grant_idx", cur_idx, cur_exp.idx);
                    chk("grant_len", cur_len, cur_exp.len);
                    chk("grant_timeout", int'(timeout), cur_exp.to);
                end
            end else begin
                chk("stray_timeout", int'(timeout), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #2 chk_zero("por");
        repeat (2) @(posedge clk);
        #7 rst_n = 1'b1;

        // Single requester 2 for three cycles; ptr becomes 3
        req = 8'b0000_0100;
        push(2, 3, 0);
        edges(3);
        req = '0;
        edges(3);

        // ptr=3, requesters 3,5,0 each drop after two granted cycles
        req = 8'b0010_1001;
        push(3, 2, 0);
        push(5, 2, 0);
        push(0, 2, 0);
        edges(2);
        req = 8'b0010_0001;
        edges(3);
        req = 8'b0000_0001;
        edges(3);
        req = '0;
        edges(3);

        // Full load after reset: 0..7,0 each revoked after HOLD cycles
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 8; i++) push(i, HOLD, 1);
        push(0, HOLD, 1);
        edges(9 * (HOLD + 1));
        req = '0;
        edges(3);

        // Lone requester 6 is revoked then regranted after GAP (ptr=1)
        req = 8'b0100_0000;
        push(6, HOLD, 1);
        push(6, HOLD, 1);
        edges(2 * (HOLD + 1));
        req = '0;
        edges(3);

        // Owner 7 releases, ptr wraps to 0, 0 beats 7
        req = 8'b1000_0000;
        push(7, 2, 0);
        push(0, 2, 0);
        edges(2);
        req = 8'b0000_0001;
        edges(1);
        req = 8'b1000_0001;
        edges(2);
        req = '0;
        edges(3);

        // Asynchronous reset mid-grant with owner 5
        req = 8'b0010_0000;
        edges(2);
        chk("pre_reset_valid", int'(gnt_valid), 1);
        chk("pre_reset_idx", int'(gnt_idx), 5);
        #1 rst_n = 1'b0;
        #1 chk_zero("midgrant_reset");
        req = 8'hFF;
        edges(2);
        #5 rst_n = 1'b1;
        push(0, 2, 0);
        edges(2);
        req = '0;
        edges(4);

        chk("queue_drained", expq.size(), 0);
        chk("grant_closed", int'(in_grant), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares a single 8-source resource among eight requesters. It registers a one-hot grant together with its 3-bit encoded index (the 8-to-3 encoding of the grant vector) and a valid flag. Each grant is held until the owner releases its request or a hold-time limit expires. The block sits in front of the encoder datapath and guarantees that the grant vector is always one-hot or all-zero.

## Interface
- HOLD_MAX, default 16: maximum consecutive cycles a single grant may stay asserted; legal range 2..255.
- CNT_W, default 8: width of the hold counter; must satisfy HOLD_MAX <= 2^CNT_W - 1.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  level request, one bit per requester; req[i] is held high until the requester is finished.
- gnt  output  8  registered one-hot grant, or all-zero.
- gnt_idx  output  3  binary index of the set gnt bit; 0 when gnt_valid=0.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX expiry.

## Operation
- State machine has three states:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
  - GAP: one mandatory dead cycle between grants for turnaround.
- Internal state:
  - ptr, 3 bits: highest-priority index for the next arbitration.
  - hold_cnt, CNT_W bits.
  - owner, 3 bits.
- Arbitration (evaluated in IDLE and GAP):
  - winner = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7 mod 8.
  - If any req bit is set, go to GRANT: owner=winner, gnt=1<<winner, gnt_idx=winner, gnt_valid=1, hold_cnt=1.
  - If req=0, go to (or stay in) IDLE with outputs zero.
- GRANT, evaluated at each edge:
  - req[owner]=0: release. gnt, gnt_idx and gnt_valid go to 0; ptr=owner+1 mod 8 (7 wraps to 0); go to GAP.
  - req[owner]=1 and hold_cnt=HOLD_MAX: revoke. Same actions as release, and timeout=1 for exactly that one cycle.
  - Otherwise: hold_cnt increments; outputs unchanged.
- Requests from other requesters during GRANT are ignored; no pre-emption except by timeout.
- A revoked requester that keeps req high is eligible again under round-robin order. If it is the only requester, it is regranted after the GAP cycle.
- gnt_idx and gnt are always consistent. gnt_valid = |gnt.
- Reset (asynchronous, at any time, including mid-grant):
  - Immediately: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - State=IDLE, ptr=0, hold_cnt=0, owner=0.
  - First arbitration happens at the first rising edge after rst_n deasserts.

## Timing
- Grant latency: req sampled high at edge N while in IDLE → gnt valid from edge N (registered output, visible in cycle N+1).
- Release latency: req[owner] sampled low at edge M → gnt low from edge M.
- GAP lasts exactly one cycle, with gnt=0. Arbitration happens at the edge that ends GAP.
- Minimum spacing between two grants is one zero cycle.
- Maximum grant length is HOLD_MAX cycles of gnt_valid=1.
- Sustained full load: period is HOLD_MAX+1 cycles per requester (HOLD_MAX granted cycles plus 1 GAP cycle).
- timeout is asserted in the first GAP cycle only, and only when the grant was revoked (never on a voluntary release).

## Test plan
- Reset, then req=8'b00000100 for 3 cycles, then 0 → gnt=8'b00000100, gnt_idx=2, gnt_valid=1 for 3 cycles; 1 GAP cycle; IDLE; ptr=3; timeout never asserted.
- ptr=3, req=8'b00101001 held, each requester dropping req after 2 granted cycles → grant order is idx 3, 5, 0; each grant lasts 2 cycles; one zero cycle between grants.
- HOLD_MAX=4, req=8'hFF constant → grant order 0,1,2,...,7,0; each grant exactly 4 cycles; timeout pulses once per grant; period 5 cycles.
- HOLD_MAX=4, req=8'b01000000 constant → gnt[6] high for 4 cycles, timeout=1 for 1 cycle, then gnt[6] regranted; pattern repeats.
- rst_n asserted low mid-grant (owner=5), asynchronously between edges → gnt, gnt_idx, gnt_valid and timeout go to 0 before the next edge. After release with req=8'hFF, the first grant goes to idx 0.
- Owner 7 releases → ptr wraps to 0. With req=8'b10000001 the next grant is idx 0, not 7.
